// File: rtl/vector_cache_pkg.sv
// rtl/vector_cache_pkg.sv - shared types for the vector cache data-array bank
package vector_cache_pkg;

  typedef enum logic {
    MODE_WORD  = 1'b0,
    MODE_SLICE = 1'b1
  } mode_e;

  localparam int VCB_NUM_LANE = 4;
  localparam int VCB_DW       = 8 * VCB_NUM_LANE;
  localparam int VCB_AW       = 8;
  localparam int VCB_SW       = $clog2(VCB_NUM_LANE);
  localparam int VCB_TAG_W    = 4;

  typedef struct packed {
    logic                    wr;
    mode_e                   mode;
    logic [VCB_SW-1:0]       sel;
    logic [VCB_AW-1:0]       addr;
    logic [VCB_DW-1:0]       wdata;
    logic [VCB_NUM_LANE-1:0] be;
    logic [VCB_TAG_W-1:0]    tag;
  } vcb_cmd_t;

endpackage

// File: rtl/vc_sram_sp.sv
// rtl/vc_sram_sp.sv - single-port byte-writable SRAM with one-cycle registered read
module vc_sram_sp #(
  parameter  int DW    = 32,
  parameter  int DEPTH = 256,
  localparam int NB    = DW / 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          wr_en_i,
  input  logic [NB-1:0] byte_wr_en_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Array contents are never reset; a write updates only its enabled bytes, a read registers the row
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (wr_en_i) begin
        for (int b = 0; b < NB; b++) begin
          if (byte_wr_en_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vc_sram_bank_xpose.sv
// rtl/vc_sram_bank_xpose.sv - multi-lane SRAM bank with word and transposed-slice access
module vc_sram_bank_xpose
  import vector_cache_pkg::*;
#(
  parameter  int NUM_LANE  = 4,
  parameter  int DEPTH     = 256,
  parameter  int TAG_W     = 4,
  parameter  int RSP_DEPTH = 4,
  localparam int DW        = 8 * NUM_LANE,
  localparam int AW        = $clog2(DEPTH),
  localparam int SW        = $clog2(NUM_LANE)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_vld_i,
  output logic                cmd_rdy_o,
  input  logic                cmd_wr_i,
  input  logic                cmd_mode_i,
  input  logic [SW-1:0]       cmd_sel_i,
  input  logic [AW-1:0]       cmd_addr_i,
  input  logic [DW-1:0]       cmd_wdata_i,
  input  logic [NUM_LANE-1:0] cmd_be_i,
  input  logic [TAG_W-1:0]    cmd_tag_i,
  output logic                rsp_vld_o,
  input  logic                rsp_rdy_i,
  output logic [DW-1:0]       rsp_data_o,
  output logic [TAG_W-1:0]    rsp_tag_o
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1) + 1;

  mode_e                              cmd_mode;
  logic                               accept;
  logic [NUM_LANE-1:0]                lane_en;
  logic [NUM_LANE-1:0][NUM_LANE-1:0]  lane_be;
  logic [NUM_LANE-1:0][DW-1:0]        lane_wdata;
  logic [NUM_LANE-1:0][DW-1:0]        lane_rdata;

  logic                               s1_vld_d, s1_vld_q;
  mode_e                              s1_mode_q;
  logic [SW-1:0]                      s1_sel_q;
  logic [TAG_W-1:0]                   s1_tag_q;
  logic [DW-1:0]                      s1_data;

  logic [DW-1:0]                      fifo_data_q [RSP_DEPTH];
  logic [TAG_W-1:0]                   fifo_tag_q  [RSP_DEPTH];
  logic [PW-1:0]                      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]                      cnt_d, cnt_q;
  logic [CW-1:0]                      occupancy;
  logic                               push, pop;

  assign cmd_mode = mode_e'(cmd_mode_i);
  assign accept   = cmd_vld_i && cmd_rdy_o;
  assign s1_vld_d = accept && !cmd_wr_i;

  // Reserve a FIFO slot for every read in flight so a response always has room; state-only path
  assign occupancy = cnt_q + CW'(s1_vld_q);
  assign cmd_rdy_o = occupancy < CW'(RSP_DEPTH);

  // Map the command onto per-lane enables, byte masks and write data (WORD: one lane, SLICE: one byte of each lane)
  always_comb begin
    lane_en    = '0;
    lane_be    = '0;
    lane_wdata = '0;
    for (int j = 0; j < NUM_LANE; j++) begin
      if (cmd_mode == MODE_WORD) begin
        lane_en[j]    = accept && (cmd_sel_i == SW'(j));
        lane_be[j]    = cmd_be_i;
        lane_wdata[j] = cmd_wdata_i;
      end else begin
        lane_en[j]    = accept && (!cmd_wr_i || cmd_be_i[j]);
        for (int k = 0; k < NUM_LANE; k++) begin
          lane_be[j][k] = cmd_be_i[j] && (cmd_sel_i == SW'(k));
        end
        lane_wdata[j] = {NUM_LANE{cmd_wdata_i[8*j +: 8]}};
      end
    end
  end

  for (genvar g = 0; g < NUM_LANE; g++) begin : g_lane
    vc_sram_sp #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_lane (
      .clk_i        (clk_i),
      .en_i         (lane_en[g]),
      .wr_en_i      (cmd_wr_i),
      .byte_wr_en_i (lane_be[g]),
      .addr_i       (cmd_addr_i),
      .wdata_i      (lane_wdata[g]),
      .rdata_o      (lane_rdata[g])
    );
  end

  // Carry read context alongside the SRAM access so steering lines up with the returned rows
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q  <= 1'b0;
      s1_mode_q <= MODE_WORD;
      s1_sel_q  <= '0;
      s1_tag_q  <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      if (s1_vld_d) begin
        s1_mode_q <= cmd_mode;
        s1_sel_q  <= cmd_sel_i;
        s1_tag_q  <= cmd_tag_i;
      end
    end
  end

  // Steer the lane read data: whole lane for WORD, byte slot sel of every lane for SLICE
  always_comb begin
    s1_data = '0;
    if (s1_mode_q == MODE_WORD) begin
      s1_data = lane_rdata[s1_sel_q];
    end else begin
      for (int j = 0; j < NUM_LANE; j++) begin
        s1_data[8*j +: 8] = lane_rdata[j][{s1_sel_q, 3'b000} +: 8];
      end
    end
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push = s1_vld_q;
  assign pop  = rsp_vld_o && rsp_rdy_i;

  // Occupancy tracks push and pop; simultaneous push and pop leave it unchanged
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Response FIFO storage and pointers; reset discards everything queued
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_tag_q[i]  <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= s1_data;
        fifo_tag_q[wr_ptr_q]  <= s1_tag_q;
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  assign rsp_vld_o  = cnt_q != '0;
  assign rsp_data_o = fifo_data_q[rd_ptr_q];
  assign rsp_tag_o  = fifo_tag_q[rd_ptr_q];

endmodule

// File: tb/tb_vc_sram_bank_xpose.sv
// tb/tb_vc_sram_bank_xpose.sv - scoreboard bench for vc_sram_bank_xpose
module tb_vc_sram_bank_xpose;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_vld, cmd_rdy, cmd_wr, cmd_mode;
  logic [1:0]  cmd_sel;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_be, cmd_tag;
  logic        rsp_vld, rsp_rdy;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;

  vc_sram_bank_xpose dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_vld_i   (cmd_vld),
    .cmd_rdy_o   (cmd_rdy),
    .cmd_wr_i    (cmd_wr),
    .cmd_mode_i  (cmd_mode),
    .cmd_sel_i   (cmd_sel),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .cmd_be_i    (cmd_be),
    .cmd_tag_i   (cmd_tag),
    .rsp_vld_o   (rsp_vld),
    .rsp_rdy_i   (rsp_rdy),
    .rsp_data_o  (rsp_data),
    .rsp_tag_o   (rsp_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    int          acc_cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  mdl [4][256][4];   // [lane][row][byte]
  int          n_pass = 0, n_total = 0, n_rsp = 0, cyc = 0, stall_cycles = 0;
  bit          rand_on;
  bit          hold_prev = 0;
  logic [31:0] prev_data;
  logic [3:0]  prev_tag;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] model_read(input logic mode, input logic [1:0] sel, input logic [7:0] addr);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = (mode == 1'b0) ? mdl[sel][addr][k] : mdl[k][addr][sel];
    return r;
  endfunction

  task automatic model_write(input logic mode, input logic [1:0] sel, input logic [7:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
    for (int k = 0; k < 4; k++) begin
      if (be[k]) begin
        if (mode == 1'b0) mdl[sel][addr][k] = wdata[8*k +: 8];
        else              mdl[k][addr][sel] = wdata[8*k +: 8];
      end
    end
  endtask

  always @(posedge clk) cyc++;

  // Issue one command (called at posedge+1); acceptance decided at the negedge before the edge
  task automatic do_cmd(input logic wr, input logic mode, input logic [1:0] sel, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input logic [3:0] tag,
                        input bit use_exp, input logic [31:0] exp_data);
    int   waited;
    exp_t e;
    cmd_vld = 1'b1; cmd_wr = wr; cmd_mode = mode; cmd_sel = sel; cmd_addr = addr;
    cmd_wdata = wdata; cmd_be = be; cmd_tag = tag;
    waited = 0;
    @(negedge clk);
    while (!cmd_rdy && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    stall_cycles += waited;
    if (!cmd_rdy) begin
      check("cmd_accept_timeout", 32'(cmd_rdy), 32'd1);
    end else if (wr) begin
      model_write(mode, sel, addr, wdata, be);
    end else begin
      e.data    = use_exp ? exp_data : model_read(mode, sel, addr);
      e.tag     = tag;
      e.acc_cyc = cyc;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: pop the scoreboard on every response handshake and check hold stability
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        check("hold_vld", 32'(rsp_vld), 32'd1);
        check("hold_data", rsp_data, prev_data);
        check("hold_tag", 32'(rsp_tag), 32'(prev_tag));
      end
      if (rsp_vld && rsp_rdy) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_tag), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
          check("rsp_latency", 32'(cyc - e.acc_cyc >= 2), 32'd1);
          n_rsp++;
        end
      end
      hold_prev = rsp_vld && !rsp_rdy;
      prev_data = rsp_data;
      prev_tag  = rsp_tag;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s0, r0;
    for (int l = 0; l < 4; l++)
      for (int a = 0; a < 256; a++)
        for (int k = 0; k < 4; k++) mdl[l][a][k] = 8'h00;
    rst_n = 1'b0; rsp_rdy = 1'b1; cmd_vld = 1'b1; cmd_wr = 1'b0; cmd_mode = 1'b0;
    cmd_sel = '0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0; cmd_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_vld", 32'(rsp_vld), 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    check("reset_rsp_tag", 32'(rsp_tag), 32'd0);
    cmd_vld = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_cmd_rdy", 32'(cmd_rdy), 32'd1);
    check("reset_no_rsp", 32'(rsp_vld), 32'd0);
    @(posedge clk); #1;

    // Pre-zero the rows the bench touches
    for (int l = 0; l < 4; l++)
      for (int a = 0; a < 16; a++) do_cmd(1, 0, 2'(l), 8'(a), 32'd0, 4'hF, 0, 0, 0);

    // Word write and read, untouched lane reads zero
    do_cmd(1, 0, 2, 5, 32'hDDCCBBAA, 4'hF, 0, 0, 0);
    do_cmd(0, 0, 2, 5, 32'd0, 4'h0, 4'h1, 1, 32'hDDCCBBAA);
    do_cmd(0, 0, 0, 5, 32'd0, 4'h0, 4'h2, 1, 32'h00000000);

    // Slice write then word and slice reads
    do_cmd(1, 1, 1, 7, 32'h44332211, 4'hF, 0, 0, 0);
    do_cmd(0, 0, 3, 7, 32'd0, 4'h0, 4'h3, 1, 32'h00004400);
    do_cmd(0, 0, 0, 7, 32'd0, 4'h0, 4'h4, 1, 32'h00001100);
    do_cmd(0, 1, 1, 7, 32'd0, 4'h0, 4'h5, 1, 32'h44332211);

    // Partial byte mask, and a zero-mask write that must change nothing
    do_cmd(1, 0, 0, 3, 32'hFFFFFFFF, 4'b0101, 0, 0, 0);
    do_cmd(0, 0, 0, 3, 32'd0, 4'h0, 4'h6, 1, 32'h00FF00FF);
    do_cmd(1, 1, 0, 3, 32'h12345678, 4'h0, 0, 0, 0);
    do_cmd(1, 1, 2, 3, 32'h9ABCDEF0, 4'h0, 0, 0, 0);
    do_cmd(0, 0, 0, 3, 32'd0, 4'h0, 4'h7, 1, 32'h00FF00FF);
    drain("drain_basic");

    // Credit: with rsp_rdy low only RSP_DEPTH reads fit
    rsp_rdy = 1'b0;
    for (int t = 0; t < 4; t++) do_cmd(0, 0, 2'(t), 5, 32'd0, 4'h0, 4'(t), 0, 0);
    @(negedge clk);
    check("credit_full_cmd_rdy", 32'(cmd_rdy), 32'd0);
    @(posedge clk); #1;
    s0 = stall_cycles;
    fork
      begin repeat (4) @(posedge clk); #1; rsp_rdy = 1'b1; end
      begin
        do_cmd(0, 1, 1, 7, 32'd0, 4'h0, 4'd4, 0, 0);
        do_cmd(0, 0, 2, 5, 32'd0, 4'h0, 4'd5, 0, 0);
      end
    join
    check("credit_stalled", 32'(stall_cycles > s0), 32'd1);
    drain("drain_credit");

    // Full-rate reads with rsp_rdy high never stall
    s0 = stall_cycles; r0 = n_rsp;
    for (int i = 0; i < 20; i++)
      do_cmd(0, 1'($urandom), 2'($urandom), 8'($urandom_range(0, 15)), 32'd0, 4'h0, 4'(i), 0, 0);
    drain("drain_stream");
    check("stream_no_stall", 32'(stall_cycles - s0), 32'd0);
    check("stream_rsp_count", 32'(n_rsp - r0), 32'd20);
    do_cmd(1, 0, 1, 9, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    do_cmd(0, 0, 1, 9, 32'd0, 4'h0, 4'h8, 1, 32'hCAFEF00D);
    drain("drain_raw");

    // Reset with reads in flight discards them; array contents survive
    do_cmd(1, 0, 1, 10, 32'h5A5A1234, 4'hF, 0, 0, 0);
    rsp_rdy = 1'b0;
    do_cmd(0, 0, 1, 10, 32'd0, 4'h0, 4'h9, 0, 0);
    do_cmd(0, 0, 2, 5, 32'd0, 4'h0, 4'hA, 0, 0);
    rst_n = 1'b0;
    #1;
    check("reset_mid_rsp_vld", 32'(rsp_vld), 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; rsp_rdy = 1'b1;
    r0 = n_rsp;
    repeat (6) @(posedge clk);
    #1;
    check("reset_no_stale_rsp", 32'(n_rsp - r0), 32'd0);
    check("reset_rsp_vld_after", 32'(rsp_vld), 32'd0);
    do_cmd(0, 0, 1, 10, 32'd0, 4'h0, 4'hB, 1, 32'h5A5A1234);
    drain("drain_reset");

    // Randomised mix against the model, with random response backpressure
    rand_on = 1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          rsp_rdy = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int i = 0; i < 300; i++)
          do_cmd(1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom_range(0, 15)),
                 $urandom, 4'($urandom), 4'($urandom), 0, 0);
        rand_on = 0;
      end
    join
    rsp_rdy = 1'b1;
    drain("drain_random");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
